// File: rtl/relay_step_sequencer.sv
// relay_step_sequencer: timed lead-switch sweep with break-before-make relay drive.
//
// Walks step_idx from 0 to NUM_STEPS-1. For each step the relays are held at 0
// for BREAK_CYCLES. The pattern is then fetched from the external table
// (step_pattern, addressed by step_idx) and applied for SETTLE_CYCLES. An
// acquisition window of DWELL_CYCLES follows.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   start        single-cycle pulse, starts a sweep when idle
//   stop         level, aborts a running sweep on the next edge
//   continuous   1 = wrap after the last step, 0 = single sweep (sampled on start)
//   step_idx     current step, addresses the external pattern table
//   step_pattern combinational pattern lookup for step_idx
//   relays       registered relay drive
//   acq_window   high while the pattern is settled and acquisition is allowed
//   step_strobe  one-cycle pulse on the first cycle of each acq_window
//   busy         high in every state except IDLE
//   done         one-cycle pulse when a single sweep or a stop completes
//
// Optional feature macro: SKIP_UNCHANGED_BREAK_EN
//   When defined, a step whose pattern equals the pattern already on the relays
//   skips BREAK and MAKE. The relays stay put and acq_window drops for one cycle.
module relay_step_sequencer #(
  parameter int NUM_STEPS     = 14,
  parameter int STEP_W        = 4,
  parameter int RELAY_W       = 8,
  parameter int BREAK_CYCLES  = 16,
  parameter int SETTLE_CYCLES = 64,
  parameter int DWELL_CYCLES  = 256,
  parameter int TIMER_W       = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               continuous,
  output logic [STEP_W-1:0]  step_idx,
  input  logic [RELAY_W-1:0] step_pattern,
  output logic [RELAY_W-1:0] relays,
  output logic               acq_window,
  output logic               step_strobe,
  output logic               busy,
  output logic               done
);
  typedef enum logic [1:0] {IDLE, BREAK, MAKE, DWELL} state_t;
  localparam logic [STEP_W-1:0]  LAST     = STEP_W'(NUM_STEPS - 1);
  localparam logic [TIMER_W-1:0] T_BREAK  = TIMER_W'(BREAK_CYCLES - 1);
  localparam logic [TIMER_W-1:0] T_SETTLE = TIMER_W'(SETTLE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] T_DWELL  = TIMER_W'(DWELL_CYCLES - 1);
  state_t             state;
  logic [TIMER_W-1:0] timer;
  logic               mode_r;
  logic               expired;
  logic [STEP_W-1:0]  next_idx;
`ifdef SKIP_UNCHANGED_BREAK_EN
  // The table only shows the pattern for the registered step_idx. The previous
  // pattern is kept for the first BREAK cycle, and the new step's pattern is
  // compared against it in that cycle.
  logic               chk;
`endif
  assign expired  = timer == '0;
  assign next_idx = (step_idx == LAST) ? '0 : step_idx + 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= IDLE;
      timer       <= '0;
      mode_r      <= 1'b0;
      step_idx    <= '0;
      relays      <= '0;
      acq_window  <= 1'b0;
      step_strobe <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
`ifdef SKIP_UNCHANGED_BREAK_EN
      chk         <= 1'b0;
`endif
    end else begin
      step_strobe <= 1'b0;
      done        <= 1'b0;
      timer       <= expired ? timer : timer - 1'b1;
      if (stop && state != IDLE) begin
        state      <= IDLE;
        timer      <= '0;
        step_idx   <= '0;
        relays     <= '0;
        acq_window <= 1'b0;
        busy       <= 1'b0;
        done       <= 1'b1;
`ifdef SKIP_UNCHANGED_BREAK_EN
        chk        <= 1'b0;
`endif
      end else begin
        case (state)
          IDLE:
            if (start && !stop) begin
              mode_r   <= continuous;
              step_idx <= '0;
              timer    <= T_BREAK;
              busy     <= 1'b1;
              state    <= BREAK;
            end
          BREAK:
`ifdef SKIP_UNCHANGED_BREAK_EN
            if (chk) begin
              chk <= 1'b0;
              if (step_pattern == relays) begin
                timer       <= T_DWELL;
                acq_window  <= 1'b1;
                step_strobe <= 1'b1;
                state       <= DWELL;
              end else begin
                relays <= '0;
                timer  <= T_BREAK;
              end
            end else
`endif
            if (expired) begin
              relays <= step_pattern;
              timer  <= T_SETTLE;
              state  <= MAKE;
            end
          MAKE:
            if (expired) begin
              timer       <= T_DWELL;
              acq_window  <= 1'b1;
              step_strobe <= 1'b1;
              state       <= DWELL;
            end
          DWELL:
            if (expired) begin
              acq_window <= 1'b0;
              if (step_idx == LAST && !mode_r) begin
                relays <= '0;
                busy   <= 1'b0;
                done   <= 1'b1;
                state  <= IDLE;
              end else begin
                step_idx <= next_idx;
                timer    <= T_BREAK;
                state    <= BREAK;
`ifdef SKIP_UNCHANGED_BREAK_EN
                chk      <= 1'b1;
`else
                relays   <= '0;
`endif
              end
            end
          default: state <= IDLE;
        endcase
      end
    end
endmodule

// File: tb/tb_relay_step_sequencer.sv
// tb_relay_step_sequencer: scoreboard bench; expected per-cycle outputs are derived from the sweep schedule.
module tb_relay_step_sequencer;
  localparam int N = 14, SW = 4, RW = 8, B = 2, S = 3, D = 4, P = B + S + D;
  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0, stop = 1'b0, continuous = 1'b0;
  logic [SW-1:0] step_idx;
  logic [RW-1:0] step_pattern, relays, noise = '0, prev = '0;
  logic acq_window, step_strobe, busy, done;
  logic [RW-1:0] pat [16];
  bit glitch_en = 1'b0, mon_en = 1'b0;
  int cyc = 0, tests = 0, fails = 0;
  typedef struct {
    int            cyc;
    logic [RW-1:0] relays;
    bit            acq, strobe, dn, bz, chk_idx;
    logic [SW-1:0] idx;
  } exp_t;
  exp_t q[$];
  exp_t e;

  relay_step_sequencer #(
    .NUM_STEPS(N), .STEP_W(SW), .RELAY_W(RW),
    .BREAK_CYCLES(B), .SETTLE_CYCLES(S), .DWELL_CYCLES(D), .TIMER_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .continuous(continuous),
    .step_idx(step_idx), .step_pattern(step_pattern), .relays(relays),
    .acq_window(acq_window), .step_strobe(step_strobe), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    noise <= RW'($urandom);
  end
  // Once a pattern is on the relays the table output is scrambled, so the bench
  // shows that only the BREAK-to-MAKE edge samples it.
  assign step_pattern = (glitch_en && relays != '0) ? noise : pat[step_idx];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(int c, logic [RW-1:0] r, bit a, bit st, bit dn, bit bz, bit ci, logic [SW-1:0] ix);
    q.push_back('{c, r, a, st, dn, bz, ci, ix});
  endtask

  // Monitor: every sampled cycle either matches a queued expectation or must be idle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (prev != '0 && relays != '0)
        check("break_before_make", 32'(relays), 32'(prev));
      while (q.size() != 0 && q[0].cyc < cyc) begin
        check("missed_entry", 32'(q[0].cyc), 32'(cyc));
        void'(q.pop_front());
      end
      if (q.size() != 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        check($sformatf("sweep_cyc_%0d", cyc),
              32'({relays, acq_window, step_strobe, done, busy, e.chk_idx ? step_idx : 4'h0}),
              32'({e.relays, e.acq, e.strobe, e.dn, e.bz, e.idx}));
      end else
        check($sformatf("idle_cyc_%0d", cyc), 32'({relays, acq_window, step_strobe, done, busy}), 32'(0));
    end
    prev = relays;
  end

  task automatic wait_drain();
    for (int i = 0; i < 2000 && q.size() != 0; i++) @(negedge clk);
    check("queue_drained", 32'(q.size()), 32'(0));
    q.delete();
  endtask

  task automatic randomize_pats();
    for (int i = 0; i < 16; i++) pat[i] = RW'($urandom_range(1, 255));
  endtask

  // Reference: k cycles after the start edge the sweep is at step (k/P)%N, phase k%P.
  // Relays are 0 during the first B cycles of a step. acq_window covers the last D
  // cycles, and the strobe marks the first of them.
  task automatic run_sweep(bit cont, int kstop, bit noisy);
    int base, total;
    @(negedge clk);
    base  = cyc + 1;
    total = cont ? kstop + 1 : N * P;
    for (int k = 0; k < total; k++) begin
      int ph, s;
      ph = k % P;
      s  = (k / P) % N;
      push(base + k, ph < B ? RW'(0) : pat[s], ph >= B + S, ph == B + S, 1'b0, 1'b1, 1'b1, SW'(s));
    end
    push(base + total, RW'(0), 1'b0, 1'b0, 1'b1, 1'b0, cont, SW'(0));
    continuous = cont;
    start = 1'b1;
    @(negedge clk);
    continuous = ~cont;
    repeat (total - 1) begin
      start = noisy && ($urandom_range(0, 7) == 0);
      @(negedge clk);
    end
    start = 1'b0;
    stop  = cont;
    @(negedge clk);
    stop = 1'b0;
    wait_drain();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) pat[i] = RW'(i + 1);
    #1 rst_n = 1'b0;
    #1 check("reset_outputs", 32'({relays, acq_window, step_strobe, done, busy, step_idx}), 32'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (3) @(negedge clk);
    run_sweep(1'b0, 0, 1'b0);
    randomize_pats();
    run_sweep(1'b0, 0, 1'b1);
    randomize_pats();
    glitch_en = 1'b1;
    run_sweep(1'b0, 0, 1'b0);
    glitch_en = 1'b0;
    randomize_pats();
    run_sweep(1'b1, P * $urandom_range(14, 17) + B + S + $urandom_range(0, D - 1), 1'b1);
    randomize_pats();
    run_sweep(1'b1, P * $urandom_range(1, 20) + $urandom_range(0, B - 1), 1'b0);
    randomize_pats();
    run_sweep(1'b1, P * $urandom_range(0, 5) + B + $urandom_range(0, S - 1), 1'b1);
    @(negedge clk);
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    repeat (2 * P) @(negedge clk);
    stop = 1'b1;
    repeat (3) @(negedge clk);
    stop = 1'b0;
    mon_en = 1'b0;
    randomize_pats();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("make_before_reset", 32'({relays, busy}), 32'({pat[0], 1'b1}));
    #2 rst_n = 1'b0;
    #1 check("async_reset_mid_make", 32'({relays, busy, acq_window, step_idx}), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    run_sweep(1'b0, 0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
